// File: rtl/mem_loader_pkg.sv
// mem_loader_pkg
// Shared definitions for the boot-time program loader: FSM state encoding,
// the memory-select command marker and the default end-of-program word.
package mem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_DECODE,
    ST_WRITE,
    ST_CHECK,
    ST_DONE
  } state_e;

  // Top byte of a word that selects the target memory.
  localparam logic [7:0]  SEL_MARKER  = 8'hA5;

  // Default end-of-program marker, zero-extended to the word width.
  localparam logic [31:0] EOP_DEFAULT = 32'h0000_0FFF;

endpackage

// File: rtl/mem_loader_packer.sv
// mem_loader_packer
// Packs received bytes MSB-first into DATA_W-bit words.
// Ports:
//   clk_i        clock
//   rst_ni       async active-low reset (discards any partial word)
//   i_clear      hold the byte counter at zero and ignore incoming bytes
//   i_dv         byte strobe
//   i_byte       received byte
//   o_word_done  combinational: the current strobe completes a word
//   o_word_vld   registered one-cycle pulse, o_word holds a complete word
//   o_word       assembled word (first byte in the top bits)
module mem_loader_packer #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              i_clear,
  input  logic              i_dv,
  input  logic [7:0]        i_byte,
  output logic              o_word_done,
  output logic              o_word_vld,
  output logic [DATA_W-1:0] o_word
);

  localparam int NBYTES = DATA_W / 8;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);

  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_shift;
  logic              r_vld;
  logic              w_take;

  assign w_take      = i_dv & ~i_clear;
  assign o_word_done = w_take & (r_cnt == LAST_IDX);
  assign o_word_vld  = r_vld;
  assign o_word      = r_shift;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt   <= '0;
      r_shift <= '0;
      r_vld   <= 1'b0;
    end else begin
      r_vld <= o_word_done;
      if (i_clear) begin
        r_cnt <= '0;
      end else if (w_take) begin
        // Shifting left means the first byte of a word ends up on top.
        r_shift <= {r_shift[DATA_W-9:0], i_byte};
        r_cnt   <= o_word_done ? '0 : r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_loader.sv
// mem_loader
// Boot-time program loader: takes UART bytes, packs them into words and
// decodes each word as a memory-select command, the end-of-program marker
// or a data word written to the selected memory at an auto-incrementing
// address. reset_o releases the core once loading has finished.
// Optional feature (macro MEM_LOADER_CHKSUM_EN): the word following the
// end-of-program marker must equal the sum of all data words; a mismatch
// flags err_o and keeps the core held.
// Ports:
//   clk_i, rst_ni         clock, async active-low reset
//   rx_dv_i, rx_byte_i    byte strobe and byte from the UART receiver
//   we_o, sel_o, addr_o,  one-cycle write strobe with one-hot memory select,
//   wdata_o               word address and data
//   busy_o                loading in progress
//   reset_o               load complete (sticky)
//   err_o                 protocol error (sticky)
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 14,
  parameter int                NUM_MEM  = 2,
  parameter logic [DATA_W-1:0] EOP_WORD = DATA_W'(EOP_DEFAULT)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               rx_dv_i,
  input  logic [7:0]         rx_byte_i,
  output logic               we_o,
  output logic [NUM_MEM-1:0] sel_o,
  output logic [ADDR_W-1:0]  addr_o,
  output logic [DATA_W-1:0]  wdata_o,
  output logic               busy_o,
  output logic               reset_o,
  output logic               err_o
);

  state_e             r_state;
  logic [2:0]         r_mem_idx;
  logic [ADDR_W-1:0]  r_addr;
  logic               r_full;     // last address already written
  logic               r_we;
  logic [NUM_MEM-1:0] r_sel;
  logic [DATA_W-1:0]  r_wdata;
  logic               r_busy;
  logic               r_reset;
  logic               r_err;
`ifdef MEM_LOADER_CHKSUM_EN
  logic [DATA_W-1:0]  r_sum;
`endif

  logic               w_word_done;
  logic               w_word_vld;
  logic [DATA_W-1:0]  w_word;
  logic [NUM_MEM-1:0] w_sel_onehot;
  logic               w_is_sel;
  logic               w_idx_ok;

  mem_loader_packer #(
    .DATA_W (DATA_W)
  ) u_packer (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .i_clear     (r_state == ST_DONE),
    .i_dv        (rx_dv_i),
    .i_byte      (rx_byte_i),
    .o_word_done (w_word_done),
    .o_word_vld  (w_word_vld),
    .o_word      (w_word)
  );

  assign w_sel_onehot = NUM_MEM'(1) << r_mem_idx;
  assign w_is_sel     = (w_word[DATA_W-1 -: 8] == SEL_MARKER);
  assign w_idx_ok     = (int'(w_word[2:0]) < NUM_MEM);

  assign we_o    = r_we;
  assign sel_o   = r_sel;
  assign addr_o  = r_addr;
  assign wdata_o = r_wdata;
  assign busy_o  = r_busy;
  assign reset_o = r_reset;
  assign err_o   = r_err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= ST_IDLE;
      r_mem_idx <= '0;
      r_addr    <= '0;
      r_full    <= 1'b0;
      r_we      <= 1'b0;
      r_sel     <= '0;
      r_wdata   <= '0;
      r_busy    <= 1'b0;
      r_reset   <= 1'b0;
      r_err     <= 1'b0;
`ifdef MEM_LOADER_CHKSUM_EN
      r_sum     <= '0;
`endif
    end else begin
      r_we <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (rx_dv_i) begin
            r_state <= ST_COLLECT;
            r_busy  <= 1'b1;
          end
        end
        // Leave on the completing strobe so the word is decoded the very
        // next cycle, while the packer presents it.
        ST_COLLECT: begin
          if (w_word_done) r_state <= ST_DECODE;
        end
        ST_DECODE: begin
          if (w_word_vld) begin
            if (w_is_sel) begin
              // An out-of-range index keeps the current selection and address.
              if (w_idx_ok) begin
                r_mem_idx <= w_word[2:0];
                r_addr    <= '0;
                r_full    <= 1'b0;
              end else begin
                r_err <= 1'b1;
              end
              r_state <= ST_COLLECT;
            end else if (w_word == EOP_WORD) begin
`ifdef MEM_LOADER_CHKSUM_EN
              r_state <= ST_CHECK;
`else
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_reset <= 1'b1;
`endif
            end else begin
`ifdef MEM_LOADER_CHKSUM_EN
              r_sum <= r_sum + w_word;
`endif
              if (r_full) begin
                r_err   <= 1'b1;
                r_state <= ST_COLLECT;
              end else begin
                r_we    <= 1'b1;
                r_sel   <= w_sel_onehot;
                r_wdata <= w_word;
                r_state <= ST_WRITE;
              end
            end
          end else begin
            r_state <= ST_COLLECT;
          end
        end
        // Address saturates at the top; the flag suppresses further writes.
        ST_WRITE: begin
          r_sel <= '0;
          if (r_addr == '1) r_full <= 1'b1;
          else              r_addr <= r_addr + 1'b1;
          r_state <= ST_COLLECT;
        end
`ifdef MEM_LOADER_CHKSUM_EN
        ST_CHECK: begin
          if (w_word_vld) begin
            if (w_word == r_sum) r_reset <= 1'b1;
            else                 r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_DONE;
          end
        end
`endif
        ST_DONE: begin
          r_state <= ST_DONE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
module tb_mem_loader;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default parameters. Instance B: ADDR_W=2 for wrap tests.
  logic        rst_a, dv_a, we_a, busy_a, reset_a, err_a;
  logic [7:0]  byte_a;
  logic [1:0]  sel_a;
  logic [13:0] addr_a;
  logic [31:0] wdata_a;

  logic        rst_b, dv_b, we_b, busy_b, reset_b, err_b;
  logic [7:0]  byte_b;
  logic [1:0]  sel_b;
  logic [1:0]  addr_b;
  logic [31:0] wdata_b;

  mem_loader u_dut_a (
    .clk_i(clk), .rst_ni(rst_a), .rx_dv_i(dv_a), .rx_byte_i(byte_a),
    .we_o(we_a), .sel_o(sel_a), .addr_o(addr_a), .wdata_o(wdata_a),
    .busy_o(busy_a), .reset_o(reset_a), .err_o(err_a)
  );

  mem_loader #(.ADDR_W(2)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_b), .rx_dv_i(dv_b), .rx_byte_i(byte_b),
    .we_o(we_b), .sel_o(sel_b), .addr_o(addr_b), .wdata_o(wdata_b),
    .busy_o(busy_b), .reset_o(reset_b), .err_o(err_b)
  );

  typedef struct packed {
    logic [1:0]  sel;
    logic [13:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_a[$];
  wr_t exp_b[$];
  wr_t ea, eb;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] EOP = 32'h0000_0FFF;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Scoreboard monitors: every write strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (we_a === 1'b1) begin
      if (exp_a.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL write_a_unexpected: got sel=%b addr=%0d data=%h, required no write",
                 sel_a, addr_a, wdata_a);
      end else begin
        ea = exp_a.pop_front();
        check("write_a_sel",  64'(sel_a),   64'(ea.sel));
        check("write_a_addr", 64'(addr_a),  64'(ea.addr));
        check("write_a_data", 64'(wdata_a), 64'(ea.data));
      end
    end
    if (we_b === 1'b1) begin
      if (exp_b.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL write_b_unexpected: got sel=%b addr=%0d data=%h, required no write",
                 sel_b, addr_b, wdata_b);
      end else begin
        eb = exp_b.pop_front();
        check("write_b_sel",  64'(sel_b),   64'(eb.sel));
        check("write_b_addr", 64'(addr_b),  64'(eb.addr));
        check("write_b_data", 64'(wdata_b), 64'(eb.data));
      end
    end
  end

  // Word-completing strobes must be at least 3 cycles apart.
  int bc_a = 0, gap_a = 100, bc_b = 0, gap_b = 100;
  always @(posedge clk) begin
    if (!rst_a) begin
      bc_a <= 0; gap_a <= 100;
    end else begin
      gap_a <= gap_a + 1;
      if (dv_a) begin
        if (bc_a == 3) begin
          assert (gap_a >= 3) else $error("FAIL word_spacing_a: gap %0d, required >= 3", gap_a);
          gap_a <= 0; bc_a <= 0;
        end else bc_a <= bc_a + 1;
      end
    end
    if (!rst_b) begin
      bc_b <= 0; gap_b <= 100;
    end else begin
      gap_b <= gap_b + 1;
      if (dv_b) begin
        if (bc_b == 3) begin
          assert (gap_b >= 3) else $error("FAIL word_spacing_b: gap %0d, required >= 3", gap_b);
          gap_b <= 0; bc_b <= 0;
        end else bc_b <= bc_b + 1;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns 1 time unit after the edge that samples the strobe.
  task automatic send_byte(input bit which, input logic [7:0] b);
    @(posedge clk); #1;
    if (!which) begin dv_a = 1'b1; byte_a = b; end
    else        begin dv_b = 1'b1; byte_b = b; end
    @(posedge clk); #1;
    dv_a = 1'b0;
    dv_b = 1'b0;
  endtask

  task automatic send_word(input bit which, input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(which, w[8*i +: 8]);
  endtask

  task automatic push_a(input logic [1:0] s, input logic [13:0] a, input logic [31:0] d);
    exp_a.push_back('{sel: s, addr: a, data: d});
  endtask

  task automatic push_b(input logic [1:0] s, input logic [13:0] a, input logic [31:0] d);
    exp_b.push_back('{sel: s, addr: a, data: d});
  endtask

  task automatic reset_a_pulse();
    @(posedge clk); #1;
    rst_a = 1'b0;
    @(posedge clk); #1;
    rst_a = 1'b1;
  endtask

  // End of program (followed by the checksum word when that feature is built)
  // and the release timing: reset_o rises two cycles after the final strobe.
  task automatic finish_load_a(input logic [31:0] sum);
`ifdef MEM_LOADER_CHKSUM_EN
    send_word(1'b0, EOP);
    send_word(1'b0, sum);
`else
    send_word(1'b0, EOP);
    if (sum == 32'h0) $display("note: checksum word unused in this build");
`endif
    check("reset_o_low_at_N", 64'(reset_a), 64'd0);
    idle(1);
    check("reset_o_high_at_N+2", 64'(reset_a), 64'd1);
    check("busy_o_low_done", 64'(busy_a), 64'd0);
  endtask

  initial begin
    rst_a = 1'b0; dv_a = 1'b0; byte_a = 8'h00;
    rst_b = 1'b0; dv_b = 1'b0; byte_b = 8'h00;
    idle(3);
    check("reset_we",    64'(we_a),    64'd0);
    check("reset_sel",   64'(sel_a),   64'd0);
    check("reset_addr",  64'(addr_a),  64'd0);
    check("reset_wdata", 64'(wdata_a), 64'd0);
    check("reset_busy",  64'(busy_a),  64'd0);
    check("reset_rst_o", 64'(reset_a), 64'd0);
    check("reset_err",   64'(err_a),   64'd0);
    rst_a = 1'b1;
    rst_b = 1'b1;
    idle(2);

    // Single data word then EOP, with write-strobe timing.
    push_a(2'b01, 14'd0, 32'hDEADBEEF);
    send_byte(1'b0, 8'hDE);
    check("busy_after_first_byte", 64'(busy_a), 64'd1);
    send_byte(1'b0, 8'hAD);
    send_byte(1'b0, 8'hBE);
    send_byte(1'b0, 8'hEF);
    check("we_low_at_N", 64'(we_a), 64'd0);
    idle(1);
    check("we_high_at_N+2", 64'(we_a), 64'd1);
    idle(1);
    check("we_low_at_N+3", 64'(we_a), 64'd0);
    check("addr_inc_at_N+3", 64'(addr_a), 64'd1);
    finish_load_a(32'hDEADBEEF);
    send_byte(1'b0, 8'h12);          // ignored in DONE
    idle(4);
    check("reset_o_sticky", 64'(reset_a), 64'd1);

    // Select memory 1, two data words.
    reset_a_pulse();
    check("reset_o_cleared", 64'(reset_a), 64'd0);
    send_word(1'b0, 32'hA5000001);
    push_a(2'b10, 14'd0, 32'h11111111);
    send_word(1'b0, 32'h11111111);
    push_a(2'b10, 14'd1, 32'h22222222);
    send_word(1'b0, 32'h22222222);
    finish_load_a(32'h33333333);
    check("err_clean_run", 64'(err_a), 64'd0);

    // Out-of-range select: error, selection stays on memory 0.
    reset_a_pulse();
    send_word(1'b0, 32'hA5000007);
    idle(3);
    check("err_bad_select", 64'(err_a), 64'd1);
    push_a(2'b01, 14'd0, 32'h33333333);
    send_word(1'b0, 32'h33333333);
    finish_load_a(32'h33333333);
    check("err_sticky", 64'(err_a), 64'd1);

    // Reset after two bytes discards the partial word.
    reset_a_pulse();
    send_byte(1'b0, 8'hAA);
    send_byte(1'b0, 8'hBB);
    reset_a_pulse();
    push_a(2'b01, 14'd0, 32'h01020304);
    send_word(1'b0, 32'h01020304);
    idle(4);
    check("busy_mid_load", 64'(busy_a), 64'd1);

`ifdef MEM_LOADER_CHKSUM_EN
    // Checksum match and mismatch.
    reset_a_pulse();
    push_a(2'b01, 14'd0, 32'h1);
    push_a(2'b01, 14'd1, 32'h2);
    send_word(1'b0, 32'h1);
    send_word(1'b0, 32'h2);
    send_word(1'b0, EOP);
    send_word(1'b0, 32'h3);
    idle(3);
    check("chk_match_reset_o", 64'(reset_a), 64'd1);
    check("chk_match_err",     64'(err_a),   64'd0);
    reset_a_pulse();
    push_a(2'b01, 14'd0, 32'h1);
    push_a(2'b01, 14'd1, 32'h2);
    send_word(1'b0, 32'h1);
    send_word(1'b0, 32'h2);
    send_word(1'b0, EOP);
    send_word(1'b0, 32'h4);
    idle(3);
    check("chk_mismatch_reset_o", 64'(reset_a), 64'd0);
    check("chk_mismatch_err",     64'(err_a),   64'd1);
`endif

    // Instance B: four writes fill addresses 0..3, the fifth is suppressed.
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) push_b(2'b01, 14'(i - 1), 32'(i));
      send_word(1'b1, 32'(i));
      idle(3);
      if (i == 4) check("b_no_err_after_4", 64'(err_b), 64'd0);
    end
    check("b_err_after_5",   64'(err_b),  64'd1);
    check("b_addr_saturated", 64'(addr_b), 64'd3);

    idle(5);
    check("a_writes_all_seen", 64'(exp_a.size()), 64'd0);
    check("b_writes_all_seen", 64'(exp_b.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
